// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the EX-side branch resolve unit: shadow pipeline entry,
// recovery FSM states and 2-bit bimodal counter encodings.
package branch_resolve_unit_pkg;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        ptaken;
        logic [31:0] ptarget;
    } shadow_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Jumps pin the entry to strongly taken; branches move one step, saturating.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                            input logic taken,
                                            input logic jump);
        logic [1:0] nxt;
        nxt = ctr;
        if (jump)
            nxt = ST;
        else if (taken && ctr != ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side prediction, EX-side resolution and BTB/redirect/flush signals
// of the branch resolve unit, bundled with master (pipeline) / slave (unit) views.
interface branch_resolve_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 if_valid;
    logic [31:0]          if_pc;
    logic                 btb_hit;
    logic [31:0]          btb_target;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic                 stall;
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic                 ex_is_jump;
    logic                 ex_taken;
    logic [31:0]          ex_target;
    logic                 br_update;
    logic [31:0]          pc_ex;
    logic [31:0]          target_pc;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 flush;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    modport master (
        output if_valid, if_pc, btb_hit, btb_target, stall,
               ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        input  pred_taken, pred_target, br_update, pc_ex, target_pc,
               redirect, redirect_pc, flush, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, btb_hit, btb_target, stall,
               ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        output pred_taken, pred_target, br_update, pc_ex, target_pc,
               redirect, redirect_pc, flush, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/branch_resolve_unit_bimodal_dir_table.sv
// 2-bit bimodal direction table: asynchronous read, synchronous saturating
// update, every entry initialised to weakly not-taken on reset.
module bimodal_dir_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken,
    input  logic                wr_jump
);
    localparam int DEPTH = 1 << IDX_BITS;

    logic [1:0] ctr_q [DEPTH];

    // Read sees the pre-write value when it collides with a same-cycle update.
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                ctr_q[i] <= WNT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken, wr_jump);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch-time predictions down to EX, resolves them against the actual
// outcome, updates the BTB and direction table, and redirects/flushes on mispredict.
module branch_resolve_unit #(
    parameter int IDX_BITS     = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);
    import branch_resolve_unit_pkg::*;

    // state   | meaning
    // IDLE    | normal operation, resolutions allowed
    // RECOVER | flush asserted for FLUSH_CYCLES cycles, EX inputs ignored

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_t                state_q, state_d;
    logic [FC_W-1:0]       fcnt_q;
    logic                  flush;
    shadow_t               s_id, s_ex;
    logic [1:0]            rd_ctr;
    logic                  resolve, act_taken, mispred;
    logic [31:0]           act_next;
    logic                  br_update_q, redirect_q;
    logic [31:0]           pc_ex_q, target_pc_q, redirect_pc_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, mispred_cnt_q;

    bimodal_dir_table #(.IDX_BITS(IDX_BITS)) u_dir (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (bus.if_pc[IDX_BITS+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (resolve),
        .wr_idx   (s_ex.pc[IDX_BITS+1:2]),
        .wr_taken (act_taken),
        .wr_jump  (bus.ex_is_jump)
    );

    assign bus.pred_taken  = bus.btb_hit & rd_ctr[1];
    assign bus.pred_target = bus.btb_target;

    assign resolve   = bus.ex_valid & s_ex.v & ~bus.stall
                     & (bus.ex_is_branch | bus.ex_is_jump)
                     & (s_ex.pc[1:0] == 2'b00) & (state_q == IDLE);
    assign act_taken = bus.ex_is_jump | bus.ex_taken;
    assign act_next  = act_taken ? bus.ex_target : s_ex.pc + 32'd4;
    assign mispred   = resolve & ((act_taken != s_ex.ptaken) |
                       (act_taken & s_ex.ptaken & (bus.ex_target != s_ex.ptarget)));

    // Flush outranks stall so squashed slots never reach EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_id <= '0;
            s_ex <= '0;
        end else if (flush) begin
            s_id.v <= 1'b0;
            s_ex.v <= 1'b0;
        end else if (!bus.stall) begin
            s_ex         <= s_id;
            s_id.v       <= bus.if_valid;
            s_id.pc      <= bus.if_pc;
            s_id.ptaken  <= bus.pred_taken;
            s_id.ptarget <= bus.pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && mispred)
                fcnt_q <= FC_W'(FLUSH_CYCLES);
            else if (state_q == RECOVER && fcnt_q != '0)
                fcnt_q <= fcnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mispred) state_d = RECOVER;
            RECOVER: if (fcnt_q <= FC_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush = 1'b0;
        if (state_q == RECOVER)
            flush = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_update_q   <= 1'b0;
            redirect_q    <= 1'b0;
            pc_ex_q       <= '0;
            target_pc_q   <= '0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_update_q <= resolve & act_taken;
            redirect_q  <= mispred;
            if (resolve && act_taken) begin
                pc_ex_q     <= s_ex.pc;
                target_pc_q <= bus.ex_target;
            end
            if (mispred)
                redirect_pc_q <= act_next;
            if (resolve && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispred && mispred_cnt_q != '1)
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end

    assign bus.br_update   = br_update_q;
    assign bus.pc_ex       = pc_ex_q;
    assign bus.target_pc   = target_pc_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.flush       = flush;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic,
// checked against a token-level model of fetch, resolution and the table.
module tb_branch_resolve_unit;
    localparam int FLUSH = 2;

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ptgt;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.CNT_WIDTH(32)) bus ();

    branch_resolve_unit #(.IDX_BITS(8), .FLUSH_CYCLES(FLUSH), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err = 0;

    int        dir [256];
    tok_t      m_id, m_ex;
    int        m_flush;
    bit [31:0] m_bc, m_mc;
    bit        e_bu, e_rd;
    bit [31:0] e_pcex, e_tpc, e_rpc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) dir[i] = 1;
        m_id = '{0, 0, 0, 0};
        m_ex = '{0, 0, 0, 0};
        m_flush = 0;
        m_bc = 0; m_mc = 0;
        e_bu = 0; e_rd = 0;
        e_pcex = 0; e_tpc = 0; e_rpc = 0;
    endtask

    task automatic step(input bit iv, input bit [31:0] ipc, input bit hit, input bit [31:0] btgt,
                        input bit st, input bit ev, input bit br, input bit jp,
                        input bit tk, input bit [31:0] etgt);
        bit        pt, flush_now, resolve, act, mis;
        bit [31:0] nxt;
        int        ix;
        @(negedge clk);
        bus.if_valid = iv;   bus.if_pc = ipc;
        bus.btb_hit = hit;   bus.btb_target = btgt;
        bus.stall = st;      bus.ex_valid = ev;
        bus.ex_is_branch = br; bus.ex_is_jump = jp;
        bus.ex_taken = tk;   bus.ex_target = etgt;
        #1;
        pt = hit && (dir[ipc[9:2]] >= 2);
        check("pred_taken", bus.pred_taken, pt);
        check("pred_target", bus.pred_target, btgt);

        flush_now = (m_flush > 0);
        resolve = ev && m_ex.v && !st && (br || jp) && (m_ex.pc[1:0] == 2'b00) && !flush_now;
        e_bu = 0; e_rd = 0; mis = 0;
        if (resolve) begin
            act = jp || tk;
            nxt = act ? etgt : m_ex.pc + 32'd4;
            mis = (act != m_ex.pt) || (act && m_ex.pt && etgt != m_ex.ptgt);
            e_bu = act;
            if (act) begin e_pcex = m_ex.pc; e_tpc = etgt; end
            e_rd = mis;
            if (mis) e_rpc = nxt;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (mis && m_mc != 32'hFFFF_FFFF) m_mc++;
            ix = m_ex.pc[9:2];
            if (jp) dir[ix] = 3;
            else if (tk) dir[ix] = (dir[ix] == 3) ? 3 : dir[ix] + 1;
            else dir[ix] = (dir[ix] == 0) ? 0 : dir[ix] - 1;
        end
        if (flush_now) begin
            m_id.v = 0; m_ex.v = 0; m_flush--;
        end else if (!st) begin
            m_ex = m_id;
            m_id = '{iv, ipc, pt, btgt};
        end
        if (mis) m_flush = FLUSH;

        @(posedge clk);
        #1;
        check("br_update", bus.br_update, e_bu);
        check("redirect", bus.redirect, e_rd);
        check("flush", bus.flush, m_flush > 0);
        check("pc_ex", bus.pc_ex, e_pcex);
        check("target_pc", bus.target_pc, e_tpc);
        check("redirect_pc", bus.redirect_pc, e_rpc);
        check("branch_cnt", bus.branch_cnt, m_bc);
        check("mispred_cnt", bus.mispred_cnt, m_mc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Fetch one instruction, let it reach EX, then resolve it.
    task automatic send(input bit [31:0] pc, input bit hit, input bit [31:0] btgt,
                        input bit br, input bit jp, input bit tk, input bit [31:0] etgt);
        idle(3);
        step(1, pc, hit, btgt, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, br, jp, tk, etgt);
    endtask

    task automatic do_reset();
        bus.if_valid = 0; bus.if_pc = 0; bus.btb_hit = 0; bus.btb_target = 0;
        bus.stall = 0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0;
        bus.ex_taken = 0; bus.ex_target = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    bit [31:0] pcs [6]  = '{32'h100, 32'h104, 32'h200, 32'hFFFF_FFFC, 32'h102, 32'h300};
    bit [31:0] tgts [3] = '{32'h200, 32'h240, 32'h104};
    bit [31:0] bc0;

    initial begin
        do_reset();
        #1;
        check("rst_flush", bus.flush, 0);
        check("rst_bcnt", bus.branch_cnt, 0);
        check("rst_redirect", bus.redirect, 0);

        // Not-taken branch, predicted not-taken.
        send(32'h100, 0, 0, 1, 0, 0, 32'h200);
        check("nt_bcnt", bus.branch_cnt, 1);
        check("nt_mcnt", bus.mispred_cnt, 0);

        // Taken branch, predicted not-taken: redirect to target, flush 2 cycles.
        send(32'h100, 0, 0, 1, 0, 1, 32'h200);
        check("tk_redirect_pc", bus.redirect_pc, 32'h200);
        check("tk_flush1", bus.flush, 1);
        idle(1);
        check("tk_flush2", bus.flush, 1);
        idle(1);
        check("tk_flush_end", bus.flush, 0);

        // Target mismatch with a strongly-taken entry.
        send(32'h100, 0, 0, 0, 1, 1, 32'h200);
        send(32'h100, 1, 32'h200, 1, 0, 1, 32'h240);
        check("tm_redirect_pc", bus.redirect_pc, 32'h240);
        check("tm_target_pc", bus.target_pc, 32'h240);

        // Predicted taken at top of memory, resolves not-taken: next PC wraps.
        send(32'hFFFF_FFFC, 0, 0, 0, 1, 1, 32'h80);
        send(32'hFFFF_FFFC, 1, 32'h80, 1, 0, 0, 32'h80);
        check("wrap_redirect_pc", bus.redirect_pc, 32'h0);
        check("wrap_br_update", bus.br_update, 0);

        // Taken branch held in EX by a 3-cycle stall resolves once.
        idle(3);
        bc0 = m_bc;
        step(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 1, 1, 0, 1, 32'h300);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h300);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h300);
        check("stall_bcnt", bus.branch_cnt, bc0 + 1);

        // Reset asserted during RECOVER.
        send(32'h200, 0, 0, 1, 0, 1, 32'h400);
        check("rr_flush_hi", bus.flush, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rr_flush_lo", bus.flush, 0);
        check("rr_bcnt", bus.branch_cnt, 0);
        check("rr_mcnt", bus.mispred_cnt, 0);
        do_reset();
        step(0, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        check("rr_table", bus.pred_taken, 0);

        // Misaligned PC never resolves.
        send(32'h102, 0, 0, 1, 0, 1, 32'h500);
        check("mis_bcnt", bus.branch_cnt, 0);

        for (int i = 0; i < 1500; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            step(($urandom % 4) != 0, pcs[$urandom_range(0, 5)], $urandom % 2,
                 tgts[$urandom_range(0, 1)], ($urandom % 6) == 0, ($urandom % 5) != 0,
                 kind == 1, kind == 2, $urandom % 2, tgts[$urandom_range(0, 2)]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
